// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
//   Instruction-fetch front end. Generates sequential word-aligned PCs, fetches
//   them over a req/gnt/rvalid memory handshake (one request outstanding at a
//   time), and buffers the returned words, tagged with their PC, in a small
//   prefetch FIFO that feeds the decode stage over valid/ready. A redirect
//   flushes the FIFO and restarts fetch at a new PC. A response already in
//   flight when the redirect arrives is dropped.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-low reset
//   start_i                  leave IDLE and begin fetching (sampled in IDLE only)
//   redirect_i/redirect_pc_i one-cycle flush + new fetch PC (low 2 bits ignored)
//   imem_req_o/imem_addr_o   fetch request and word address
//   imem_gnt_i               request accepted this cycle
//   imem_rvalid_i/_rdata_i   in-order response, at least one cycle after grant
//   inst_valid_o/inst_o/     FIFO head (word and its PC); the head holds its
//   inst_pc_o                last value while the FIFO is empty
//   inst_ready_i             consumer pops the head
// ---------------------------------------------------------------------------
module if_prefetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2               // 2..8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;   // next PC to request
  logic [31:0]   pend_pc_q, pend_pc_d;     // PC of the request in flight
  logic          drop_q, drop_d;           // discard the next response
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   last_inst_q, last_inst_d; // head shown while empty
  logic [31:0]   last_pc_q, last_pc_d;

  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];

  logic          req, push, pop, flush;
  logic [31:0]   addr, redirect_pc_al;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign redirect_pc_al = redirect_pc_i & 32'hFFFF_FFFC;

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? fifo_inst[rd_ptr_q] : last_inst_q;
  assign inst_pc_o    = inst_valid_o ? fifo_pc[rd_ptr_q]   : last_pc_q;
  assign imem_req_o   = req;
  assign imem_addr_o  = addr;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    drop_d     = drop_q;
    req        = 1'b0;
    addr       = '0;
    push       = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = ISSUE;
      end

      ISSUE: begin
        // In ISSUE nothing is in flight, so credit reduces to FIFO space.
        req  = (count_q < DEPTH_C);
        addr = fetch_pc_q;
        if (redirect_i) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc_al;
          // A request granted in the redirect cycle is stale: drop its data.
          if (req && imem_gnt_i) begin
            state_d = WAIT;
            drop_d  = 1'b1;
          end
        end else if (req && imem_gnt_i) begin
          pend_pc_d  = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        if (redirect_i) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc_al;
          if (imem_rvalid_i) begin
            drop_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (drop_q) drop_d = 1'b0;
          else        push   = 1'b1;
          state_d = ISSUE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Flush wins over a concurrent pop.
    pop = inst_valid_o && inst_ready_i && !flush;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    last_inst_d = inst_o;
    last_pc_d   = inst_pc_o;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      pend_pc_q   <= '0;
      drop_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_inst_q <= '0;
      last_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_pc_q   <= pend_pc_d;
      drop_q      <= drop_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      last_inst_q <= last_inst_d;
      last_pc_q   <= last_pc_d;
    end
  end

  // NOTE: the FIFO storage is not reset; an entry is only ever read after it
  // was written, because count_q gates every read of the array.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_inst[wr_ptr_q] <= imem_rdata_i;
      fifo_pc[wr_ptr_q]   <= pend_pc_q;
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_stage
//   Three instances: A (RESET_PC=0, DEPTH=2), B (RESET_PC=0, DEPTH=4) and
//   C (RESET_PC=FFFF_FFF8, DEPTH=2). A behavioural memory answers the selected
//   instance with words derived from the address, so every delivered word can
//   be checked against its PC tag. The reference for delivered PCs is the
//   architectural stream: consecutive words, restarting at each redirect.
// ---------------------------------------------------------------------------
module tb_if_prefetch_stage;

  localparam int N = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        start    [N];
  logic        redirect [N];
  logic [31:0] rpc      [N];
  logic        gnt      [N];
  logic        rvalid   [N];
  logic [31:0] rdata    [N];
  logic        ready    [N];
  logic        req      [N];
  logic [31:0] addr     [N];
  logic        valid    [N];
  logic [31:0] inst     [N];
  logic [31:0] ipc      [N];

  if_prefetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start[0]), .redirect_i(redirect[0]),
    .redirect_pc_i(rpc[0]), .imem_req_o(req[0]), .imem_addr_o(addr[0]),
    .imem_gnt_i(gnt[0]), .imem_rvalid_i(rvalid[0]), .imem_rdata_i(rdata[0]),
    .inst_valid_o(valid[0]), .inst_o(inst[0]), .inst_pc_o(ipc[0]),
    .inst_ready_i(ready[0]));

  if_prefetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start[1]), .redirect_i(redirect[1]),
    .redirect_pc_i(rpc[1]), .imem_req_o(req[1]), .imem_addr_o(addr[1]),
    .imem_gnt_i(gnt[1]), .imem_rvalid_i(rvalid[1]), .imem_rdata_i(rdata[1]),
    .inst_valid_o(valid[1]), .inst_o(inst[1]), .inst_pc_o(ipc[1]),
    .inst_ready_i(ready[1]));

  if_prefetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_c (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start[2]), .redirect_i(redirect[2]),
    .redirect_pc_i(rpc[2]), .imem_req_o(req[2]), .imem_addr_o(addr[2]),
    .imem_gnt_i(gnt[2]), .imem_rvalid_i(rvalid[2]), .imem_rdata_i(rdata[2]),
    .inst_valid_o(valid[2]), .inst_o(inst[2]), .inst_pc_o(ipc[2]),
    .inst_ready_i(ready[2]));

  int total = 0;
  int bad   = 0;

  // Memory model state for the selected instance.
  int          sel      = 0;
  int          gnt_pct  = 100;
  int          lat_max  = 1;
  bit          hold_en  = 1'b0;
  logic [31:0] hold_addr = '0;
  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_wait = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // One clock of stimulus: at the falling edge, answer the memory handshake,
  // drive consumer/redirect inputs and report whether a pop will take place.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt,
                      output bit popped, output logic [31:0] pc,
                      output logic [31:0] data, output bit proto_bad);
    @(negedge clk_i);
    for (int i = 0; i < N; i++) begin
      gnt[i] = 1'b0; rvalid[i] = 1'b0; ready[i] = 1'b0; redirect[i] = 1'b0;
    end
    proto_bad = 1'b0;
    if (mem_pend) begin
      if (req[sel]) proto_bad = 1'b1;
      mem_wait--;
      if (mem_wait <= 0) begin
        rvalid[sel] = 1'b1;
        rdata[sel]  = mem_word(mem_addr);
        mem_pend    = 1'b0;
      end
    end
    if (req[sel] && !mem_pend && ($urandom_range(99) < gnt_pct)) begin
      gnt[sel] = 1'b1;
      mem_pend = 1'b1;
      mem_addr = addr[sel];
      mem_wait = (hold_en && addr[sel] == hold_addr) ? 1000 : int'($urandom_range(lat_max, 1));
    end
    ready[sel]    = rdy;
    redirect[sel] = redir;
    rpc[sel]      = tgt;
    popped = valid[sel] && rdy && !redir;
    pc     = ipc[sel];
    data   = inst[sel];
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0; redirect[i] = 1'b0; rpc[i] = '0; gnt[i] = 1'b0;
      rvalid[i] = 1'b0; rdata[i] = '0; ready[i] = 1'b0;
    end
    mem_pend = 1'b0; hold_en = 1'b0; gnt_pct = 100; lat_max = 1;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic start_dut();
    @(negedge clk_i);
    start[sel] = 1'b1;
    @(negedge clk_i);
    start[sel] = 1'b0;
  endtask

  // Step with ready low until the request for 'a' is in flight.
  task automatic wait_grant(input logic [31:0] a, input string name);
    bit p, pb; logic [31:0] pc, d;
    for (int c = 0; c < 30 && !(mem_pend && mem_addr == a); c++) step(1'b0, 1'b0, '0, p, pc, d, pb);
    total++;
    if (!(mem_pend && mem_addr == a)) begin
      bad++; $display("FAIL %s_grant_timeout: no grant for %h", name, a);
    end
  endtask

  // Pop with ready high and compare the next 'n' instructions from 'first'.
  task automatic expect_pops(input logic [31:0] first, input int n, input string name);
    bit p, pb; logic [31:0] pc, d; logic [31:0] exp; int got;
    exp = first; got = 0;
    for (int c = 0; c < 20 * n && got < n; c++) begin
      step(1'b1, 1'b0, '0, p, pc, d, pb);
      if (p) begin
        total++;
        if (pc !== exp || d !== mem_word(exp)) begin
          bad++; $display("FAIL %s_pop%0d: pc=%h inst=%h, want pc=%h inst=%h", name, got, pc, d, exp, mem_word(exp));
        end
        exp += 32'd4; got++;
      end
    end
    total++;
    if (got != n) begin bad++; $display("FAIL %s_timeout: popped %0d of %0d", name, got, n); end
  endtask

  task automatic test_reset();
    int req_cycles;
    sel = 0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    total++;
    if ({req[0], addr[0], valid[0], inst[0], ipc[0]} !== '0) begin
      bad++; $display("FAIL reset_outputs: req=%b addr=%h valid=%b inst=%h pc=%h, want all 0",
                      req[0], addr[0], valid[0], inst[0], ipc[0]);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    req_cycles = 0;
    for (int c = 0; c < 5; c++) begin @(negedge clk_i); if (req[0] || valid[0]) req_cycles++; end
    total++;
    if (req_cycles != 0) begin bad++; $display("FAIL reset_no_start: activity in %0d cycles, want 0", req_cycles); end
  endtask

  task automatic test_sequential();
    do_reset(); sel = 0;
    @(negedge clk_i);
    start[0] = 1'b1;
    total++;
    if (req[0] !== 1'b0) begin bad++; $display("FAIL seq_req_before: got %b want 0", req[0]); end
    @(posedge clk_i); #1;
    start[0] = 1'b0;
    total++;
    if (req[0] !== 1'b1 || addr[0] !== 32'h0) begin
      bad++; $display("FAIL seq_req_after: req=%b addr=%h, want 1/00000000", req[0], addr[0]);
    end
    expect_pops(32'h0, 3, "seq");
  endtask

  task automatic test_backpressure();
    bit p, pb; logic [31:0] pc, d; int grants;
    do_reset(); sel = 0; start_dut();
    for (int c = 0; c < 12; c++) step(1'b0, 1'b0, '0, p, pc, d, pb);
    total++;
    if (req[0] !== 1'b0 || valid[0] !== 1'b1 || ipc[0] !== 32'h0 || inst[0] !== mem_word(32'h0)) begin
      bad++; $display("FAIL bp_full: req=%b valid=%b pc=%h inst=%h, want 0/1/00000000/%h",
                      req[0], valid[0], ipc[0], inst[0], mem_word(32'h0));
    end
    step(1'b1, 1'b0, '0, p, pc, d, pb);
    total++;
    if (!p || pc !== 32'h0) begin bad++; $display("FAIL bp_pop: popped=%b pc=%h, want 1/00000000", p, pc); end
    grants = 0;
    for (int c = 0; c < 10; c++) begin step(1'b0, 1'b0, '0, p, pc, d, pb); if (gnt[0]) grants++; end
    total++;
    if (grants != 1 || ipc[0] !== 32'h4 || req[0] !== 1'b0) begin
      bad++; $display("FAIL bp_refill: grants=%0d pc=%h req=%b, want 1/00000004/0", grants, ipc[0], req[0]);
    end
  endtask

  task automatic test_redirect_wait();
    bit p, pb; logic [31:0] pc, d;
    do_reset(); sel = 1; hold_en = 1'b1; hold_addr = 32'h8; start_dut();
    wait_grant(32'h8, "rw");
    step(1'b0, 1'b0, '0, p, pc, d, pb);
    total++;
    if (valid[1] !== 1'b1 || ipc[1] !== 32'h0) begin
      bad++; $display("FAIL rw_before: valid=%b pc=%h, want 1/00000000", valid[1], ipc[1]);
    end
    step(1'b0, 1'b1, 32'h103, p, pc, d, pb);
    mem_wait = 1; hold_en = 1'b0;   // stale response for 0x8 arrives next cycle
    step(1'b0, 1'b0, '0, p, pc, d, pb);
    total++;
    if (valid[1] !== 1'b0) begin bad++; $display("FAIL rw_flush: valid=%b want 0", valid[1]); end
    expect_pops(32'h100, 2, "rw");
  endtask

  task automatic test_redirect_rvalid_pop();
    bit p, pb; logic [31:0] pc, d;
    do_reset(); sel = 0; hold_en = 1'b1; hold_addr = 32'h4; start_dut();
    wait_grant(32'h4, "rvp");
    total++;
    if (valid[0] !== 1'b1) begin bad++; $display("FAIL rvp_has_head: valid=%b want 1", valid[0]); end
    mem_wait = 1; hold_en = 1'b0;   // response, pop and redirect in one cycle
    step(1'b1, 1'b1, 32'h40, p, pc, d, pb);
    step(1'b0, 1'b0, '0, p, pc, d, pb);
    total++;
    if (valid[0] !== 1'b0 || req[0] !== 1'b1 || addr[0] !== 32'h40) begin
      bad++; $display("FAIL rvp_after: valid=%b req=%b addr=%h, want 0/1/00000040", valid[0], req[0], addr[0]);
    end
    expect_pops(32'h40, 2, "rvp");
  endtask

  task automatic test_pc_wrap();
    do_reset(); sel = 2; start_dut();
    expect_pops(32'hFFFF_FFF8, 3, "wrap");
  endtask

  task automatic test_reset_mid_wait();
    bit p, pb; logic [31:0] pc, d; int act;
    do_reset(); sel = 0; hold_en = 1'b1; hold_addr = 32'h4; start_dut();
    wait_grant(32'h4, "rmw");
    step(1'b0, 1'b0, '0, p, pc, d, pb);
    total++;
    if (valid[0] !== 1'b1 || inst[0] !== mem_word(32'h0)) begin
      bad++; $display("FAIL rmw_before: valid=%b inst=%h, want 1/%h", valid[0], inst[0], mem_word(32'h0));
    end
    #2 rst_i = 1'b0;
    #1;
    total++;
    if ({req[0], addr[0], valid[0], inst[0], ipc[0]} !== '0) begin
      bad++; $display("FAIL rmw_reset: req=%b addr=%h valid=%b inst=%h pc=%h, want all 0",
                      req[0], addr[0], valid[0], inst[0], ipc[0]);
    end
    mem_pend = 1'b0; hold_en = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rvalid[0] = 1'b1; rdata[0] = 32'hDEAD_BEEF;
    @(negedge clk_i);
    rvalid[0] = 1'b0;
    act = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk_i); if (req[0] || valid[0]) act++; end
    total++;
    if (act != 0) begin bad++; $display("FAIL rmw_stray: activity in %0d cycles, want 0", act); end
    start_dut();
    expect_pops(32'h0, 2, "rmw");
  endtask

  task automatic test_random();
    bit p, pb, rdy, redir; logic [31:0] pc, d, tgt, exp, prev_addr;
    bit prev_req, prev_gnt, prev_redir; int pops;
    for (int s = 0; s < 2; s++) begin
      do_reset(); sel = s; gnt_pct = 70; lat_max = 3; start_dut();
      exp = 32'h0; pops = 0;
      prev_req = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0; prev_addr = '0;
      for (int c = 0; c < 1500; c++) begin
        rdy   = ($urandom_range(99) < 60);
        redir = ($urandom_range(99) < 4);
        tgt   = $urandom;
        step(rdy, redir, tgt, p, pc, d, pb);
        total++;
        if (pb) begin bad++; $display("FAIL rnd%0d_second_req: cycle %0d req while outstanding", s, c); end
        if (prev_req && !prev_gnt && !prev_redir) begin
          total++;
          if (req[sel] !== 1'b1 || addr[sel] !== prev_addr) begin
            bad++; $display("FAIL rnd%0d_req_stable: req=%b addr=%h, want 1/%h", s, req[sel], addr[sel], prev_addr);
          end
        end
        if (p) begin
          total++;
          if (pc !== exp || d !== mem_word(exp)) begin
            bad++; $display("FAIL rnd%0d_pop: pc=%h inst=%h, want pc=%h inst=%h", s, pc, d, exp, mem_word(exp));
          end
          exp += 32'd4; pops++;
        end
        if (redir) exp = tgt & 32'hFFFF_FFFC;
        prev_req = req[sel]; prev_gnt = gnt[sel]; prev_redir = redir; prev_addr = addr[sel];
      end
      total++;
      if (pops < 50) begin bad++; $display("FAIL rnd%0d_progress: %0d pops, want >= 50", s, pops); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0; redirect[i] = 1'b0; rpc[i] = '0; gnt[i] = 1'b0;
      rvalid[i] = 1'b0; rdata[i] = '0; ready[i] = 1'b0;
    end
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid_pop();
    test_pc_wrap();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
